// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC output scheduler.
package dac_sched_pkg;

   localparam int unsigned NUM_SRC  = 3;
   localparam int unsigned SAMPLE_W = 14;
   localparam int unsigned IDX_W    = 2;

   localparam logic [SAMPLE_W-1:0] IDLE_CODE_DFLT = 14'h2000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   // Index of the set bit in a one-hot requester vector (0 when empty).
   function automatic logic [IDX_W-1:0] oh_to_idx(input logic [NUM_SRC-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (oh[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_owner, wrapping.
module rr_arbiter
   import dac_sched_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   last_owner,
   output logic [NUM_SRC-1:0] grant
);

   // Walk candidates from farthest to nearest so the nearest valid one wins.
   always_comb begin
      logic [IDX_W-1:0] idx;
      grant = '0;
      idx   = '0;
      for (int unsigned k = NUM_SRC; k >= 1; k--) begin
         idx = IDX_W'((32'(last_owner) + k) % NUM_SRC);
         if (req[idx]) grant = NUM_SRC'(1) << idx;
      end
   end

endmodule

// File: rtl/dac_out_sched.sv
// Burst scheduler muxing three sample sources onto a single registered DAC port,
// with round-robin ownership, idle-code gaps and a starvation guard.
module dac_out_sched
   import dac_sched_pkg::*;
#(
   parameter int unsigned             BURST_LEN = 64,
   parameter int unsigned             GAP_CYC   = 2,
   parameter logic [SAMPLE_W-1:0]     IDLE_CODE = IDLE_CODE_DFLT
)
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic [NUM_SRC-1:0]          req_valid,
   input  logic [NUM_SRC*SAMPLE_W-1:0] req_data,
   output logic [NUM_SRC-1:0]          req_ready,
   output logic [SAMPLE_W-1:0]         dac_data,
   output logic                        dac_valid,
   output logic [NUM_SRC-1:0]          grant,
   output logic                        burst_done
);

   localparam int unsigned CNT_W = $clog2(BURST_LEN);
   localparam int unsigned GAP_W = 4;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [NUM_SRC-1:0]   grant_d;
   logic [SAMPLE_W-1:0]  dac_data_d;
   logic                 dac_valid_d;
   logic                 burst_done_d;

   logic [NUM_SRC-1:0]   arb_grant;
   logic [SAMPLE_W-1:0]  owner_sample;
   logic                 accept;
   logic                 owner_valid;
   logic                 other_valid;
   logic                 end_burst;

   rr_arbiter u_arb (
      .req        (req_valid),
      .last_owner (last_q),
      .grant      (arb_grant)
   );

   assign req_ready   = (state_q == ST_BURST && en) ? grant : '0;
   assign accept      = |(req_valid & req_ready);
   assign owner_valid = |(req_valid & grant);
   assign other_valid = |(req_valid & ~grant);

   // Sample belonging to the current owner.
   always_comb begin
      owner_sample = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (grant[i]) owner_sample = req_data[i*SAMPLE_W +: SAMPLE_W];
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      gap_d        = gap_q;
      last_d       = last_q;
      grant_d      = grant;
      dac_data_d   = dac_data;
      dac_valid_d  = 1'b0;
      burst_done_d = 1'b0;
      end_burst    = 1'b0;

      if (!en) begin
         state_d    = ST_IDLE;
         grant_d    = '0;
         cnt_d      = '0;
         gap_d      = '0;
         dac_data_d = IDLE_CODE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               dac_data_d = IDLE_CODE;
               if (|req_valid) begin
                  grant_d = arb_grant;
                  cnt_d   = '0;
                  state_d = ST_BURST;
               end
            end
            ST_BURST: begin
               if (accept) begin
                  dac_data_d  = owner_sample;
                  dac_valid_d = 1'b1;
                  cnt_d       = cnt_q + CNT_W'(1);
                  end_burst   = (cnt_q == CNT_W'(BURST_LEN - 1));
               end else if (!owner_valid && other_valid) begin
                  end_burst = 1'b1;
               end
               if (end_burst) begin
                  state_d      = ST_GAP;
                  burst_done_d = 1'b1;
                  last_d       = oh_to_idx(grant);
                  grant_d      = '0;
                  cnt_d        = '0;
                  gap_d        = '0;
               end
            end
            ST_GAP: begin
               dac_data_d = IDLE_CODE;
               if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                  state_d = ST_IDLE;
                  gap_d   = '0;
               end else begin
                  gap_d = gap_q + GAP_W'(1);
               end
            end
            default: begin
               state_d    = ST_IDLE;
               grant_d    = '0;
               dac_data_d = IDLE_CODE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         gap_q      <= '0;
         last_q     <= IDX_W'(NUM_SRC - 1);
         grant      <= '0;
         dac_data   <= IDLE_CODE;
         dac_valid  <= 1'b0;
         burst_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         last_q     <= last_d;
         grant      <= grant_d;
         dac_data   <= dac_data_d;
         dac_valid  <= dac_valid_d;
         burst_done <= burst_done_d;
      end
   end

endmodule

// File: tb/tb_dac_out_sched.sv
// Scoreboard bench for dac_out_sched: random and directed traffic against a
// phase-level reference model; a monitor checks every registered output cycle.
module tb_dac_out_sched;

   localparam int unsigned BL   = 4;
   localparam int unsigned GC   = 2;
   localparam logic [13:0] IDLE = 14'h2000;

   typedef struct {
      logic [13:0] data;
      logic        valid;
      logic [2:0]  grant;
      logic        done;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [2:0]  req_valid = '0;
   logic [41:0] req_data = '0;
   logic [2:0]  req_ready;
   logic [13:0] dac_data;
   logic        dac_valid;
   logic [2:0]  grant;
   logic        burst_done;

   dac_out_sched #(.BURST_LEN(BL), .GAP_CYC(GC), .IDLE_CODE(IDLE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .dac_data   (dac_data),
      .dac_valid  (dac_valid),
      .grant      (grant),
      .burst_done (burst_done)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   exp_t        exp_q[$];
   logic [13:0] samp_q[$];

   // Reference model: phase 0 idle, 1 burst, 2 gap.
   int          m_phase = 0;
   int          m_owner = 0;
   int          m_taken = 0;
   int          m_gap_left = 0;
   int          m_last = 2;
   logic [13:0] m_out = IDLE;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   function automatic logic [2:0] model_ready(input logic e);
      if (m_phase == 1 && e) return 3'b001 << m_owner;
      return 3'b000;
   endfunction

   // Advance the model one clock and queue the outputs it predicts after that edge.
   task automatic model_step(input logic rst, input logic e, input logic [2:0] v,
                             input logic [41:0] d);
      exp_t r;
      r.valid = 1'b0;
      r.done  = 1'b0;
      if (!rst) begin
         m_phase = 0; m_last = 2; m_owner = 0; m_taken = 0; m_out = IDLE;
      end else if (!e) begin
         m_phase = 0; m_out = IDLE;
      end else begin
         case (m_phase)
            0: begin
               m_out = IDLE;
               if (v != 3'b000) begin
                  for (int k = 3; k >= 1; k--)
                     if (v[(m_last + k) % 3]) m_owner = (m_last + k) % 3;
                  m_taken = 0;
                  m_phase = 1;
               end
            end
            1: begin
               if (v[m_owner]) begin
                  m_out   = d[m_owner*14 +: 14];
                  r.valid = 1'b1;
                  samp_q.push_back(m_out);
                  m_taken++;
               end
               if ((r.valid && m_taken == BL) ||
                   (!v[m_owner] && (v & ~(3'b001 << m_owner)) != 3'b000)) begin
                  r.done     = 1'b1;
                  m_last     = m_owner;
                  m_phase    = 2;
                  m_gap_left = GC;
               end
            end
            default: begin
               m_out = IDLE;
               m_gap_left--;
               if (m_gap_left == 0) m_phase = 0;
            end
         endcase
      end
      r.data  = m_out;
      r.grant = (m_phase == 1) ? (3'b001 << m_owner) : 3'b000;
      exp_q.push_back(r);
   endtask

   // Called at a falling edge: apply inputs, check ready, predict, wait a cycle.
   task automatic drive(input logic e, input logic [2:0] v, input logic [41:0] d);
      en        = e;
      req_valid = v;
      req_data  = d;
      #1;
      chk("req_ready", 32'(req_ready), 32'(model_ready(e)));
      model_step(rst_n, e, v, d);
      @(negedge clk);
   endtask

   function automatic logic [41:0] rnd_data();
      return {14'($urandom), 14'($urandom), 14'($urandom)};
   endfunction

   // Monitor: compare every registered output cycle against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("grant",      32'(grant),      32'(e.grant));
            chk("dac_valid",  32'(dac_valid),  32'(e.valid));
            chk("burst_done", 32'(burst_done), 32'(e.done));
            chk("dac_data",   32'(dac_data),   32'(e.data));
            if (dac_valid) begin
               if (samp_q.size() == 0) chk("sample_pending", 32'(dac_valid), 32'd0);
               else chk("sample", 32'(dac_data), 32'(samp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      logic [41:0] d;
      @(negedge clk);
      for (int i = 0; i < 3; i++) drive(1'b0, 3'b000, '0);
      rst_n = 1'b1;

      // Single requester 0 with a known first sample.
      d = rnd_data();
      d[13:0] = 14'h0123;
      drive(1'b1, 3'b001, d);
      drive(1'b1, 3'b001, d);
      drive(1'b1, 3'b001, d);
      for (int i = 0; i < 8; i++) drive(1'b1, 3'b001, rnd_data());

      // All three continuously valid: rotating bursts.
      for (int i = 0; i < 30; i++) drive(1'b1, 3'b111, rnd_data());

      // Owner 0 drops after two accepts while requester 1 waits.
      for (int i = 0; i < 40 && !(m_phase == 1 && m_owner == 0 && m_taken == 2); i++)
         drive(1'b1, 3'b001, rnd_data());
      for (int i = 0; i < 8; i++) drive(1'b1, 3'b010, rnd_data());

      // Requester 2 alone stalls for ten cycles mid-burst.
      for (int i = 0; i < 40 && !(m_phase == 1 && m_owner == 2 && m_taken == 2); i++)
         drive(1'b1, 3'b100, rnd_data());
      for (int i = 0; i < 10; i++) drive(1'b1, 3'b000, rnd_data());
      for (int i = 0; i < 6; i++) drive(1'b1, 3'b100, rnd_data());

      // Enable dropped on what would be the final accept of a burst.
      for (int i = 0; i < 40 && !(m_phase == 1 && m_taken == BL - 1); i++)
         drive(1'b1, 3'b001, rnd_data());
      drive(1'b0, 3'b001, rnd_data());
      for (int i = 0; i < 6; i++) drive(1'b1, 3'b001, rnd_data());

      // Asynchronous reset between edges in the middle of a burst.
      for (int i = 0; i < 40 && !(m_phase == 1 && m_taken == 1); i++)
         drive(1'b1, 3'b010, rnd_data());
      en = 1'b1; req_valid = 3'b010; req_data = rnd_data();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_dac_data",   32'(dac_data),   32'(IDLE));
      chk("rst_dac_valid",  32'(dac_valid),  32'd0);
      chk("rst_grant",      32'(grant),      32'd0);
      chk("rst_burst_done", 32'(burst_done), 32'd0);
      chk("rst_req_ready",  32'(req_ready),  32'd0);
      exp_q.delete();
      samp_q.delete();
      model_step(1'b0, en, req_valid, req_data);
      @(negedge clk);
      drive(1'b1, 3'b111, rnd_data());
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) drive(1'b1, 3'b111, rnd_data());

      // Randomised traffic with occasional enable drops.
      for (int i = 0; i < 400; i++)
         drive(($urandom_range(0, 19) != 0), 3'($urandom), rnd_data());

      for (int i = 0; i < 3; i++) drive(1'b0, 3'b000, '0);
      chk("exp_q_drained",  32'(exp_q.size()),  32'd0);
      chk("samp_q_drained", 32'(samp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
